// File: rtl/adder_pkg.sv
// Shared types and defaults for the digit-serial adder/subtractor.
package adder_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n states; never narrower than one bit so NDIG=1 still has a counter.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT_W-bit adder slice; also exposes the carry into its MSB for overflow detection.
module digit_adder #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co,
    output logic               cm
);

    logic [DIGIT_W:0]   full;
    logic [DIGIT_W-1:0] cvec;

    always_comb begin
        full = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, ci};
        s    = full[DIGIT_W-1:0];
        co   = full[DIGIT_W];
        // sum bit = x ^ y ^ carry_in, so the per-bit carry-in is recovered by xor-ing back
        cvec = x ^ y ^ full[DIGIT_W-1:0];
        cm   = cvec[DIGIT_W-1];
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: one DIGIT_W digit per clock, LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by DIGIT_SERIAL_ADDER_OVF_EN.
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operand pair
//   RUN   | adding digit cnt, carry held in register
//   DONE  | out_valid=1, result held until out_ready
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DIGIT_W = DEF_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int CW   = cnt_w(NDIG);
    localparam logic [CW-1:0]    LAST  = CW'(NDIG - 1);
    localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT_W{1'b1}});

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   opa, opb;
    logic               carry;
    logic [CW-1:0]      cnt;
    logic               load, step;
    int                 off;
    logic [DIGIT_W-1:0] dx, dy, ds;
    logic               dco, dcm;

    assign off = DIGIT_W * int'(cnt);
    assign dx  = DIGIT_W'(opa >> off);
    assign dy  = DIGIT_W'(opb >> off);

    digit_adder #(.DIGIT_W(DIGIT_W)) u_digit (
        .x (dx),
        .y (dy),
        .ci(carry),
        .s (ds),
        .co(dco),
        .cm(dcm)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (load) begin
                // subtraction is a + ~b + ~borrow_in
                opa   <= a;
                opb   <= sub ? ~b : b;
                carry <= sub ? ~cin : cin;
                cnt   <= '0;
            end else if (step) begin
                sum   <= (sum & ~(DMASK << off)) | (WIDTH'(ds) << off);
                carry <= dco;
                if (cnt == LAST) begin
                    cout <= dco;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                    ovf  <= dcm ^ dco;
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifndef DIGIT_SERIAL_ADDER_OVF_EN
    logic unused_cm;
    assign unused_cm = dcm;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: random and directed operands against an arithmetic model.
module tb_digit_serial_adder;

    parameter int DIGIT_W = 4;
    localparam int WIDTH = 16;
    localparam int NDIG  = WIDTH / DIGIT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        int               acc;
        int               stall;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Plain integer arithmetic: unsigned result for sum/cout, signed result for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c, input logic s);
        exp_t   e;
        longint ux, uy, sx, sy, r, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r  = ux - uy - longint'(c);
            sr = sx - sy - longint'(c);
            e.co = (r >= 0);
        end else begin
            r  = ux + uy + longint'(c);
            sr = sx + sy + longint'(c);
            e.co = (r >= (longint'(1) << WIDTH));
        end
        e.s     = WIDTH'(r);
        e.ov    = (sr > ((longint'(1) << (WIDTH-1)) - 1)) || (sr < -(longint'(1) << (WIDTH-1)));
        e.acc   = 0;
        e.stall = 0;
        return e;
    endfunction

    task automatic garbage(input bit vld);
        in_valid = vld;
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input logic ts, input int stall, input int gap);
        int   waited = 0;
        int   g = gap;
        exp_t e;
        forever begin
            @(negedge clk);
            if (in_ready && g == 0) break;
            if (in_ready) begin
                g--;
                garbage(1'b0);
            end else begin
                garbage(1'($urandom_range(0, 1)));
            end
            waited++;
            if (waited > 8 * NDIG + 60) begin
                check("accept_timeout", in_ready, 1'b1);
                return;
            end
        end
        in_valid = 1'b1;
        a = ta; b = tb_; cin = tc; sub = ts;
        e = model(ta, tb_, tc, ts);
        e.acc   = cyc;
        e.stall = stall;
        q.push_back(e);
        @(posedge clk);
        #1;
        garbage(1'($urandom_range(0, 1)));
    endtask

    // Monitor: pops on the first out_valid cycle, then checks hold and release behaviour.
    initial begin : monitor
        exp_t cur;
        bit   hs_pend = 1'b0;
        int   stall   = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_busy  = 1'b0;
                hs_pend   = 1'b0;
                stall     = 0;
                out_ready = 1'b0;
                continue;
            end
            if (hs_pend) begin
                check("valid_after_handshake", out_valid, 1'b0);
                check("ready_after_handshake", in_ready, 1'b1);
                hs_pend  = 1'b0;
                mon_busy = 1'b0;
            end else if (mon_busy) begin
                check("valid_held", out_valid, 1'b1);
                if (!out_valid) mon_busy = 1'b0;
            end
            if (out_valid && !mon_busy && !hs_pend) begin
                if (q.size() == 0) begin
                    check("spurious_result", q.size(), 1);
                end else begin
                    cur      = q.pop_front();
                    mon_busy = 1'b1;
                    stall    = cur.stall;
                    check("latency", cyc - cur.acc, 1 + NDIG);
                end
            end
            if (out_valid && mon_busy) begin
                check("sum", sum, cur.s);
                check("cout", cout, cur.co);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                check("ovf", ovf, cur.ov);
`endif
                check("in_ready_done", in_ready, 1'b0);
            end
            if (mon_busy && stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (mon_busy && out_valid && out_ready) hs_pend = 1'b1;
        end
    end

    typedef struct {
        logic [WIDTH-1:0] x, y;
        logic c, s;
        int stall;
    } vec_t;

    vec_t dir[$];

    initial begin : main
        int   waited;
        logic [WIDTH-1:0] picks [5];
        rst_n = 1'b0;
        garbage(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        dir.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 0});
        dir.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0});
        dir.push_back('{16'hFFFF, 16'h0001, 1'b1, 1'b0, 0});
        dir.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 0});
        dir.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 5});
        dir.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 0});
        dir.push_back('{16'h8000, 16'h7FFF, 1'b0, 1'b1, 5});
        dir.push_back('{16'h0003, 16'h0004, 1'b0, 1'b0, 0});
        foreach (dir[i]) issue(dir[i].x, dir[i].y, dir[i].c, dir[i].s, dir[i].stall, 0);

        picks[0] = 16'h0000; picks[1] = 16'hFFFF; picks[2] = 16'h8000; picks[3] = 16'h7FFF;
        for (int i = 0; i < 60; i++) begin
            logic [WIDTH-1:0] ra, rb;
            picks[4] = WIDTH'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : WIDTH'($urandom);
            issue(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        in_valid = 1'b0;

        waited = 0;
        while ((q.size() != 0 || mon_busy) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("drain_pending", q.size(), 0);
        repeat (3) @(negedge clk);

        // Abort an operation with reset on its second RUN cycle (the only one when NDIG=1).
        check("idle_before_abort", in_ready, 1'b1);
        in_valid = 1'b1;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat ((NDIG >= 2) ? 1 : 0) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_sum", sum, '0);
        check("abort_cout", cout, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NDIG + 4; i++) begin
            @(negedge clk);
            check("abort_no_result", out_valid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes one DIGIT_W-bit digit per clock, LSB digit first, with the carry held in a register between digits.
- Accepts one operand pair through a valid/ready input handshake. Returns sum and carry-out through a valid/ready output handshake.
- Used where a full-width ripple adder is too slow or too large. Sits between the operand register file and the result bus of the arithmetic datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of DIGIT_W.
- DIGIT_W, 4, bits added per clock cycle; 1 <= DIGIT_W <= WIDTH.
- NDIG (localparam), WIDTH/DIGIT_W, number of RUN cycles per operation.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (borrow-in when sub=1).
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out; when sub=1 this is NOT borrow (1 = no borrow).

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-low.
- Reset state: state=IDLE, in_ready=1 (IDLE decode), out_valid=0, sum=0, cout=0, digit counter=0, carry register=0.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1. Accept occurs when in_valid && in_ready.
    - On accept, latch a into opA.
    - Latch b into opB, inverted if sub=1.
    - Set carry := sub ? ~cin : cin.
    - Set counter := 0, then go to RUN.
    - a, b, cin and sub are sampled only on this edge and ignored afterwards.
  - RUN: in_ready=0. Each cycle, digit k = counter adds opA[k], opB[k] and carry.
    - Write the DIGIT_W-bit result into sum[k*DIGIT_W +: DIGIT_W].
    - Update carry with the digit's carry-out.
    - When counter==NDIG-1: cout := final carry, then go to DONE. Otherwise counter+1.
  - DONE: out_valid=1 and in_ready=0. sum and cout are held stable while out_ready=0.
    - When out_valid && out_ready, go to IDLE on the next edge; out_valid drops to 0.
- Latency and throughput:
  - out_valid rises exactly NDIG cycles after the accepting edge.
  - Minimum issue interval is NDIG+2 cycles, because there is no accept while in DONE.
- Boundary conditions:
  - NDIG=1 (DIGIT_W==WIDTH): a single RUN cycle, identical protocol.
  - Carry ripples across all digits, e.g. 0xFFFF+1.
  - in_valid asserted during RUN or DONE is ignored and not queued.
  - out_ready asserted outside DONE has no effect.
- Reset mid-operation: rst_n=0 in any state returns the block to the reset state on that edge. The partial result is discarded and no out_valid is produced.
- sum bits for digits not yet computed are don't-care until out_valid=1. The bench checks sum only when out_valid=1.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow flag.
  - ovf = (carry into MSB) XOR (carry out of MSB), captured on the final RUN cycle.
  - Valid and held with out_valid; reset value 0.
- When undefined: no ovf port and no associated logic.

Decomposition:
- Package adder_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - Function clog2-based counter width helper.
  - Default WIDTH/DIGIT_W constants.
- Sub-module digit_adder:
  - Purely combinational DIGIT_W-bit ripple adder.
  - Inputs: x, y, ci.
  - Outputs: s, co, and the carry into its MSB (used for ovf).
  - The top level instantiates it once and time-multiplexes it across digits.

Test Plan:
- WIDTH=16, DIGIT_W=4. a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0; out_valid exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1 (carry through all 4 digits). With cin=1 -> sum=0x0001, cout=1.
- Subtraction:
  - a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0.
  - a=0x0007, b=0x0005, sub=1, cin=1 -> sum=0x0001, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum and cout stable, in_ready=0, and in_valid pulses ignored. out_ready=1 -> IDLE next cycle with in_ready=1.
- Reset on the 2nd RUN cycle -> next cycle IDLE, out_valid=0, in_ready=1, sum=0. No result appears for the aborted operation.
- With DIGIT_SERIAL_ADDER_OVF_EN:
  - a=0x7FFF + b=0x0001 -> sum=0x8000, ovf=1.
  - a=0x8000 - b=0x7FFF -> sum=0x0001, ovf=1.
  - a=0x0003 + b=0x0004 -> ovf=0.
  - Repeat with DIGIT_W=16 (NDIG=1) and DIGIT_W=1 (NDIG=16); latency matches NDIG.
